blk_stream_checker: RTL and testbench
=====================================

# blk_stream_checker

Synthesizable, parametrised round-trip checker for the 8x8 block stream. It buffers the reference stream (the rows fed into a forward/inverse transform chain) and compares it, row by row and lane by lane, against the stream returned by the chain, within a configurable modular tolerance. It also checks block framing on the returned stream and keeps saturating error counters. It sits beside any `dct_*_wrapper` chain in FPGA self-test builds and replaces bench-only scoreboards.

## Interface
- `W`, 8: sample width in bits, per lane.
- `LANES`, 8: samples per row.
- `ROWS`, 8: rows per block; `eob` is expected on row `ROWS-1`.
- `DEPTH`, 64: reference FIFO depth in rows, power of two, ≥ chain latency in rows.
- `TOL`, 1: allowed |ref − dut| modulo 2^W. The value must be < 2^(W-1).
- `CW`, 16: error counter width.
- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: global enable. When it is 0, there are no pushes, no pops, no compares, and the counters hold.
- `clr` in 1: synchronous clear of the counters, the sticky flags and the FIFO. It takes effect only when `en`=1.
- `ref_valid`, `ref_eob`, `ref_sob`, `ref_sof` in 1: reference row strobe and sideband.
- `ref_data` in LANES×W: reference row, packed `[LANES-1:0][W-1:0]`.
- `dut_valid`, `dut_eob`, `dut_sob`, `dut_sof` in 1: returned row strobe and sideband.
- `dut_data` in LANES×W: returned row.
- `data_err_cnt` out CW: number of rows with at least one lane out of tolerance.
- `ctrl_err_cnt` out CW: number of rows whose {eob,sob,sof} differs from the reference.
- `frame_err_cnt` out CW: number of framing violations on the dut stream.
- `unmatched_cnt` out CW: number of dut rows that arrived while the FIFO was empty.
- `lane_err_mask` out LANES: per-lane mismatch mask of the most recent compare.
- `overflow` out 1: sticky flag; a reference row was dropped because the FIFO was full.
- `pass` out 1: high when all four counters are 0 and `overflow`=0.

## Operation
- **Push.** The checker pushes {ref_data, ref_eob, ref_sob, ref_sof} when `en & ref_valid`.
- **Push when full.** If the FIFO is full and no pop occurs in the same cycle, the row is dropped and `overflow` is set.
- **Push and pop together when full.** This is legal; both happen and no overflow is flagged.
- **Pop.** The checker pops on `en & dut_valid` when the FIFO is not empty.
- **Pop when empty.** A dut row arriving with the FIFO empty is not compared. `unmatched_cnt` increments, and it does so even if a push happens in the same cycle.
- **Data compare.** For each lane, d = (ref − dut) mod 2^W. The lane passes when d ≤ TOL or d ≥ 2^W − TOL.
  - `lane_err_mask[i]` is set to the per-lane fail bit.
  - `data_err_cnt` increments by at most 1 per row.
- **Ctrl compare.** The 3-bit {eob,sob,sof} of the reference and dut rows must be equal; otherwise `ctrl_err_cnt` increments.
- **Framing FSM** on dut rows (`en & dut_valid`):
  - IDLE:
    - `sob`=1 → row count = 1; stay in IDLE if ROWS=1 and `eob`=1, otherwise go to BLOCK.
    - `sob`=0 → frame error; stay in IDLE.
  - BLOCK:
    - `sob`=1 → frame error; restart the block (row count = 1).
    - Otherwise the row count increments.
    - `eob`=1 at row count ROWS-1 (pre-increment) → go to IDLE.
    - `eob` on any other row, or its absence on row ROWS-1 → frame error; go to IDLE.
  - `sof` is legal only together with `sob`; `sof` on any other row is a frame error.
  - At most one frame error is counted per row.
- **Counters.** All counters saturate at 2^CW − 1.
- **`clr`.** It has priority over every other update in the same cycle. It empties the FIFO, returns the FSM to IDLE, and clears the mask.

## Timing
- **Reset values.** On `rst_n`=0 every output is 0; `pass` is 1. The FIFO is empty and the FSM is in IDLE.
- **Compare latency.** The compare is pipelined one stage. Counters and `lane_err_mask` update 2 cycles after the `dut_valid` edge: one cycle for the FIFO read and operand register, one for the compare and counter update.
- **`unmatched_cnt` latency.** It updates 1 cycle after the edge.
- **`pass`.** It is a registered combination of the counter and flag registers.
- **Push-to-pop.** The minimum latency from push to poppable is 1 cycle; a row pushed at edge N can be popped at edge N+1.
- **`en` low mid-pipeline.** The in-flight compare stage is frozen and completes once `en` returns to 1.
- **Reset mid-block.** It discards the FIFO contents and the pipeline; nothing is counted.

## Structure
- Shared package `blk_chk_pkg` contains:
  - `blk_ctrl_t` packed struct {eob, sob, sof};
  - `frame_state_e` {IDLE, BLOCK};
  - the function `within_tol(a, b, tol)`.
- The natural sub-module is `sync_row_fifo`: a parameterised synchronous FIFO (width, depth) with registered read, plus `full`/`empty` outputs and same-cycle push/pop when full.
- The top level holds the framing FSM, the compare stage and the counters.

## Test plan
- **Loopback, exact.** Feed 4 blocks of random rows, with dut = ref delayed by 5 rows. Expect all counters 0 and `pass`=1.
- **Tolerance boundary.** Use W=8, TOL=1 on lane 3, with ref=0 against dut = 1, 255 and 2. Expect `data_err_cnt`=1 and `lane_err_mask`=8'h08 on the third row only.
- **Framing.** Send a dut block with `eob` on row 5, then a block with no `sob`. Expect `frame_err_cnt`=2, with `ctrl_err_cnt` nonzero against a correct reference.
- **Overflow.** Use DEPTH=4, push 5 rows with no pops. Expect `overflow`=1 and `pass`=0. Then repeat with push and pop in the same cycle while full: no overflow.
- **Unmatched row.** A `dut_valid` row with the FIFO empty gives `unmatched_cnt`=1 after 1 cycle.
- **Saturation and clear.** Use CW=4 and inject 20 data mismatches. Expect `data_err_cnt`=15. Assert `clr` for one cycle: all counters 0 and `pass`=1 on the next cycle.

Source files
------------

// File: rtl/blk_chk_pkg.sv
// Shared types and helpers for the 8x8 block-stream round-trip checker.
package blk_chk_pkg;

    typedef struct packed {
        logic eob;
        logic sob;
        logic sof;
    } blk_ctrl_t;

    localparam int unsigned CTRL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } frame_state_e;

    // Operands arrive MSB-aligned in 32 bits, so 32-bit wraparound equals mod 2^W.
    function automatic logic within_tol(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] tol);
        logic [31:0] d_ab;
        logic [31:0] d_ba;
        d_ab = a - b;
        d_ba = b - a;
        return (d_ab <= tol) || (d_ba <= tol);
    endfunction

endpackage

// File: rtl/sync_row_fifo.sv
// Synchronous row FIFO with registered read; push and pop together while full
// is accepted.
module sync_row_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full_c,
    output logic             empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == (AW + 1)'(DEPTH));
    assign empty_c = (count == '0);
    assign do_pop  = pop & ~clr & ~empty_c;
    assign do_push = push & ~clr & (~full_c | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (do_pop) begin
            rdata <= mem[rptr];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/blk_stream_checker.sv
// Round-trip checker: buffers reference rows, compares them against the returned
// stream within a modular tolerance, checks block framing, keeps error counters.
module blk_stream_checker
    import blk_chk_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 8,
    parameter int unsigned ROWS  = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned TOL   = 1,
    parameter int unsigned CW    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      ref_valid,
    input  logic                      ref_eob,
    input  logic                      ref_sob,
    input  logic                      ref_sof,
    input  logic [LANES-1:0][W-1:0]   ref_data,
    input  logic                      dut_valid,
    input  logic                      dut_eob,
    input  logic                      dut_sob,
    input  logic                      dut_sof,
    input  logic [LANES-1:0][W-1:0]   dut_data,
    output logic [CW-1:0]             data_err_cnt,
    output logic [CW-1:0]             ctrl_err_cnt,
    output logic [CW-1:0]             frame_err_cnt,
    output logic [CW-1:0]             unmatched_cnt,
    output logic [LANES-1:0]          lane_err_mask,
    output logic                      overflow,
    output logic                      pass
);
    localparam int unsigned ROW_W   = LANES * W;
    localparam int unsigned ENTRY_W = ROW_W + CTRL_W;
    localparam int unsigned RC_W    = $clog2(ROWS + 1);
    localparam int unsigned ALIGN   = 32 - W;
    localparam logic [0:0]  S_IDLE  = 1'(IDLE);
    localparam logic [0:0]  S_BLOCK = 1'(BLOCK);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic               clr_c;
    logic               push_c;
    logic               pop_c;
    logic               full_c;
    logic               empty_c;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign clr_c    = en & clr;
    assign push_c   = en & ref_valid;
    assign pop_c    = en & dut_valid;
    assign wr_entry = {ref_data, ref_eob, ref_sob, ref_sof};

    sync_row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_c),
        .push    (push_c),
        .wdata   (wr_entry),
        .pop     (pop_c),
        .rdata   (rd_entry),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Stage 1: FIFO read and dut operand register.
    logic                    s1_valid;
    logic [LANES-1:0][W-1:0] dut_row_q;
    blk_ctrl_t               dut_ctrl_q;
    logic [LANES-1:0][W-1:0] ref_row;
    blk_ctrl_t               ref_ctrl;

    assign ref_row  = rd_entry[ENTRY_W-1:CTRL_W];
    assign ref_ctrl = blk_ctrl_t'(rd_entry[CTRL_W-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            dut_row_q  <= '0;
            dut_ctrl_q <= '0;
        end else if (clr_c) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= pop_c & ~empty_c;
            if (pop_c & ~empty_c) begin
                dut_row_q  <= dut_data;
                dut_ctrl_q <= '{eob: dut_eob, sob: dut_sob, sof: dut_sof};
            end
        end
    end

    // Stage 2: per-lane tolerance and sideband compare.
    logic [LANES-1:0] lane_fail_c;
    logic             data_row_err_c;
    logic             ctrl_row_err_c;

    always_comb begin
        lane_fail_c = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_fail_c[i] = ~within_tol(32'(ref_row[i]) << ALIGN,
                                         32'(dut_row_q[i]) << ALIGN,
                                         32'(TOL) << ALIGN);
        end
    end

    assign data_row_err_c = s1_valid & (|lane_fail_c);
    assign ctrl_row_err_c = s1_valid & (ref_ctrl != dut_ctrl_q);

    // Framing FSM on the returned stream; row count is the index of the next row.
    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [RC_W-1:0] rcnt_q;
    logic [RC_W-1:0] rcnt_d;
    logic            frame_err_c;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_c) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
        end else if (en) begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        frame_err_c = 1'b0;
        if (pop_c) begin
            if (dut_sof && !dut_sob) begin
                frame_err_c = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (dut_sob) begin
                        rcnt_d  = RC_W'(1);
                        state_d = (ROWS == 1 && dut_eob) ? S_IDLE : S_BLOCK;
                    end else begin
                        frame_err_c = 1'b1;
                    end
                end
                default: begin
                    if (dut_sob) begin
                        frame_err_c = 1'b1;
                        rcnt_d      = RC_W'(1);
                    end else if (rcnt_q == RC_W'(ROWS - 1)) begin
                        state_d = S_IDLE;
                        if (!dut_eob) begin
                            frame_err_c = 1'b1;
                        end
                    end else if (dut_eob) begin
                        frame_err_c = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        rcnt_d = rcnt_q + RC_W'(1);
                    end
                end
            endcase
        end
    end

    // Saturating counters, sticky overflow and the registered pass summary.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_c) begin
            data_err_cnt  <= '0;
            ctrl_err_cnt  <= '0;
            frame_err_cnt <= '0;
            unmatched_cnt <= '0;
            lane_err_mask <= '0;
            overflow      <= 1'b0;
            pass          <= 1'b1;
        end else begin
            if (en) begin
                if (s1_valid) begin
                    lane_err_mask <= lane_fail_c;
                end
                if (data_row_err_c && data_err_cnt != CNT_MAX) begin
                    data_err_cnt <= data_err_cnt + CW'(1);
                end
                if (ctrl_row_err_c && ctrl_err_cnt != CNT_MAX) begin
                    ctrl_err_cnt <= ctrl_err_cnt + CW'(1);
                end
                if (frame_err_c && frame_err_cnt != CNT_MAX) begin
                    frame_err_cnt <= frame_err_cnt + CW'(1);
                end
                if (pop_c && empty_c && unmatched_cnt != CNT_MAX) begin
                    unmatched_cnt <= unmatched_cnt + CW'(1);
                end
                if (push_c && full_c && !pop_c) begin
                    overflow <= 1'b1;
                end
            end
            pass <= (data_err_cnt == '0) && (ctrl_err_cnt == '0) &&
                    (frame_err_cnt == '0) && (unmatched_cnt == '0) && !overflow;
        end
    end

endmodule

// File: tb/tb_blk_stream_checker.sv
// Bench for blk_stream_checker: hand sequences, a vector table and a queue-based
// reference model driven with random traffic.
module tb_blk_stream_checker;
    localparam int unsigned W       = 8;
    localparam int unsigned LANES   = 8;
    localparam int unsigned ROWS    = 8;
    localparam int unsigned TOL     = 1;
    localparam int          DEPTH_A = 64;
    localparam int          CMAX_A  = 65535;

    typedef logic [LANES-1:0][W-1:0] row_data_t;
    typedef struct packed {
        row_data_t d;
        logic      eob;
        logic      sob;
        logic      sof;
    } row_t;
    typedef struct {
        logic [7:0] lane3;
        logic [7:0] mask;
        int         cnt;
    } tol_vec_t;

    logic      clk = 1'b0;
    logic      rst_n, en, clr;
    logic      ref_valid, ref_eob, ref_sob, ref_sof;
    logic      dut_valid, dut_eob, dut_sob, dut_sof;
    row_data_t ref_data, dut_data;

    logic [15:0] a_data, a_ctrl, a_frame, a_unm;
    logic [7:0]  a_mask;
    logic        a_ovf, a_pass;
    logic [3:0]  b_data, b_ctrl, b_frame, b_unm;
    logic [7:0]  b_mask;
    logic        b_ovf, b_pass;

    always #5 clk = ~clk;

    blk_stream_checker u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .ref_valid(ref_valid), .ref_eob(ref_eob), .ref_sob(ref_sob), .ref_sof(ref_sof),
        .ref_data(ref_data),
        .dut_valid(dut_valid), .dut_eob(dut_eob), .dut_sob(dut_sob), .dut_sof(dut_sof),
        .dut_data(dut_data),
        .data_err_cnt(a_data), .ctrl_err_cnt(a_ctrl), .frame_err_cnt(a_frame),
        .unmatched_cnt(a_unm), .lane_err_mask(a_mask), .overflow(a_ovf), .pass(a_pass)
    );

    blk_stream_checker #(.DEPTH(4), .CW(4)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .ref_valid(ref_valid), .ref_eob(ref_eob), .ref_sob(ref_sob), .ref_sof(ref_sof),
        .ref_data(ref_data),
        .dut_valid(dut_valid), .dut_eob(dut_eob), .dut_sob(dut_sob), .dut_sof(dut_sof),
        .dut_data(dut_data),
        .data_err_cnt(b_data), .ctrl_err_cnt(b_ctrl), .frame_err_cnt(b_frame),
        .unmatched_cnt(b_unm), .lane_err_mask(b_mask), .overflow(b_ovf), .pass(b_pass)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model for instance A: a queue stands in for the FIFO.
    row_t       mq[$];
    int         m_data, m_ctrl, m_frame, m_unm, m_pos;
    logic       m_ovf, m_inblk;
    logic [7:0] m_mask;

    task automatic model_reset();
        mq.delete();
        m_data = 0; m_ctrl = 0; m_frame = 0; m_unm = 0; m_pos = 0;
        m_ovf = 1'b0; m_inblk = 1'b0; m_mask = '0;
    endtask

    task automatic model_step();
        logic fe;
        if (!en) return;
        if (clr) begin
            model_reset();
            return;
        end
        if (dut_valid) begin
            if (mq.size() == 0) begin
                if (m_unm < CMAX_A) m_unm++;
            end else begin
                row_t       r;
                logic [7:0] msk;
                r   = mq.pop_front();
                msk = '0;
                for (int i = 0; i < LANES; i++) begin
                    int d;
                    d = (int'(r.d[i]) - int'(dut_data[i])) & 255;
                    if (!(d <= int'(TOL) || d >= 256 - int'(TOL))) msk[i] = 1'b1;
                end
                m_mask = msk;
                if (msk != 0 && m_data < CMAX_A) m_data++;
                if ({r.eob, r.sob, r.sof} != {dut_eob, dut_sob, dut_sof} && m_ctrl < CMAX_A)
                    m_ctrl++;
            end
            fe = dut_sof && !dut_sob;
            if (!m_inblk) begin
                if (dut_sob) begin
                    m_pos = 1;
                    m_inblk = !(ROWS == 1 && dut_eob);
                end else fe = 1'b1;
            end else if (dut_sob) begin
                fe = 1'b1;
                m_pos = 1;
            end else if (m_pos == int'(ROWS) - 1) begin
                m_inblk = 1'b0;
                if (!dut_eob) fe = 1'b1;
            end else if (dut_eob) begin
                fe = 1'b1;
                m_inblk = 1'b0;
            end else m_pos++;
            if (fe && m_frame < CMAX_A) m_frame++;
        end
        if (ref_valid) begin
            if (mq.size() < DEPTH_A) mq.push_back({ref_data, ref_eob, ref_sob, ref_sof});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        ref_valid = 1'b0; dut_valid = 1'b0;
    endtask

    task automatic set_ref(input logic v, input row_t r);
        ref_valid = v; ref_data = r.d; ref_eob = r.eob; ref_sob = r.sob; ref_sof = r.sof;
    endtask

    task automatic set_dut(input logic v, input row_t r);
        dut_valid = v; dut_data = r.d; dut_eob = r.eob; dut_sob = r.sob; dut_sof = r.sof;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b0;
        idle();
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_clr();
        en = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        model_reset();
    endtask

    function automatic row_t make_row(input int idx);
        row_t r;
        r.d   = {$urandom, $urandom};
        r.sob = (idx % ROWS) == 0;
        r.eob = (idx % ROWS) == ROWS - 1;
        r.sof = (idx % (4 * ROWS)) == 0;
        return r;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " data_err_cnt"}, 32'(a_data), 32'(m_data));
        chk({tag, " ctrl_err_cnt"}, 32'(a_ctrl), 32'(m_ctrl));
        chk({tag, " frame_err_cnt"}, 32'(a_frame), 32'(m_frame));
        chk({tag, " unmatched_cnt"}, 32'(a_unm), 32'(m_unm));
        chk({tag, " lane_err_mask"}, 32'(a_mask), 32'(m_mask));
        chk({tag, " overflow"}, 32'(a_ovf), 32'(m_ovf));
        chk({tag, " pass"}, 32'(a_pass),
            32'(m_data == 0 && m_ctrl == 0 && m_frame == 0 && m_unm == 0 && !m_ovf));
    endtask

    // Random traffic: well-framed reference blocks, returned rows delayed and optionally corrupted.
    task automatic random_run(input int ncyc, input int noise, input string tag);
        row_t cq[$];
        int   ri  = 0;
        int   blk = 0;
        row_t r;
        do_reset();
        for (int c = 0; c < ncyc + 300; c++) begin
            logic drain;
            drain = (c >= ncyc);
            if (drain && cq.size() == 0) break;
            en  = drain ? 1'b1 : ($urandom_range(0, 7) != 0);
            r   = make_row(ri);
            r.sof = (ri == 0) && (blk % 4 == 0);
            set_ref(!drain && cq.size() < 40 && $urandom_range(0, 4) < 3, r);
            if (cq.size() > (drain ? 0 : 5) && $urandom_range(0, 4) < 3) begin
                row_t x;
                x = cq[0];
                if (noise > 0 && $urandom_range(0, noise) == 1) begin
                    int k;
                    k = $urandom_range(0, LANES - 1);
                    x.d[k] = x.d[k] + 8'($urandom_range(0, 4)) - 8'd2;
                end
                if (noise > 0 && $urandom_range(0, 2 * noise) == 1) x.eob = ~x.eob;
                set_dut(1'b1, x);
                if (en) cq.delete(0);
            end else if (noise > 0 && cq.size() == 0 && $urandom_range(0, 19) == 0) begin
                set_dut(1'b1, make_row($urandom_range(0, 7)));
            end else begin
                dut_valid = 1'b0;
            end
            if (en && ref_valid) begin
                cq.push_back(r);
                ri = (ri + 1) % ROWS;
                if (ri == 0) blk++;
            end
            model_step();
            tick();
        end
        idle(); en = 1'b1;
        repeat (4) tick();
        check_model(tag);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tol_vec_t tv[6];
        row_t     r, x;
        row_t     blk_rows[40];
        int       prev;

        tv[0] = '{8'd1,   8'h00, 0};
        tv[1] = '{8'd255, 8'h00, 0};
        tv[2] = '{8'd2,   8'h08, 1};
        tv[3] = '{8'd254, 8'h08, 2};
        tv[4] = '{8'd0,   8'h00, 2};
        tv[5] = '{8'd128, 8'h08, 3};

        ref_data = '0; dut_data = '0;
        ref_eob = 0; ref_sob = 0; ref_sof = 0; dut_eob = 0; dut_sob = 0; dut_sof = 0;
        do_reset();
        chk("reset data_err_cnt", 32'(a_data), 0);
        chk("reset frame_err_cnt", 32'(a_frame), 0);
        chk("reset lane_err_mask", 32'(a_mask), 0);
        chk("reset overflow", 32'(a_ovf), 0);
        chk("reset pass", 32'(a_pass), 1);

        // Exact loopback: 4 blocks, returned stream delayed by 5 rows.
        for (int i = 0; i < 32; i++) blk_rows[i] = make_row(i);
        for (int i = 0; i < 37; i++) begin
            set_ref(i < 32, blk_rows[i < 32 ? i : 0]);
            set_dut(i >= 5, blk_rows[i >= 5 ? i - 5 : 0]);
            tick();
        end
        idle(); repeat (3) tick();
        chk("loopback data_err_cnt", 32'(a_data), 0);
        chk("loopback ctrl_err_cnt", 32'(a_ctrl), 0);
        chk("loopback frame_err_cnt", 32'(a_frame), 0);
        chk("loopback unmatched_cnt", 32'(a_unm), 0);
        chk("loopback pass", 32'(a_pass), 1);

        // Tolerance boundary table on lane 3 with reference 0.
        do_reset();
        prev = 0;
        for (int v = 0; v < 6; v++) begin
            r = '0;
            r.d = {$urandom, $urandom};
            r.d[3] = 8'd0;
            x = r;
            x.d[3] = tv[v].lane3;
            set_ref(1'b1, r); tick();
            idle(); set_dut(1'b1, x); tick();
            idle();
            chk($sformatf("tol[%0d] latency", v), 32'(a_data), 32'(prev));
            tick();
            chk($sformatf("tol[%0d] lane_err_mask", v), 32'(a_mask), 32'(tv[v].mask));
            chk($sformatf("tol[%0d] data_err_cnt", v), 32'(a_data), 32'(tv[v].cnt));
            prev = tv[v].cnt;
        end
        chk("tol ctrl_err_cnt", 32'(a_ctrl), 0);

        // Framing: eob on row 5, then a row without sob.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_ref(1'b1, blk_rows[i]); tick();
        end
        idle();
        for (int i = 0; i < 7; i++) begin
            x = blk_rows[i];
            if (i == 5) x.eob = 1'b1;
            set_dut(1'b1, x); tick();
        end
        idle(); repeat (3) tick();
        chk("framing frame_err_cnt", 32'(a_frame), 2);
        chk("framing ctrl_err_cnt", 32'(a_ctrl), 1);
        chk("framing data_err_cnt", 32'(a_data), 0);
        chk("framing pass", 32'(a_pass), 0);

        // Overflow on the 4-deep instance, then push+pop while full.
        do_reset();
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r.d = {$urandom, $urandom};
            set_ref(1'b1, r); tick();
        end
        idle(); tick(); tick();
        chk("overflow flag", 32'(b_ovf), 1);
        chk("overflow pass", 32'(b_pass), 0);
        chk("overflow deep instance", 32'(a_ovf), 0);
        do_clr();
        chk("overflow cleared", 32'(b_ovf), 0);
        blk_rows[0] = '0; blk_rows[0].d = {$urandom, $urandom}; blk_rows[0].sob = 1'b1;
        set_ref(1'b1, blk_rows[0]); tick();
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r.d = {$urandom, $urandom};
            set_ref(1'b1, r);
            if (i == 3) set_dut(1'b1, blk_rows[0]);
            tick();
        end
        idle(); repeat (3) tick();
        chk("full push+pop overflow", 32'(b_ovf), 0);
        chk("full push+pop data_err_cnt", 32'(b_data), 0);
        chk("full push+pop frame_err_cnt", 32'(b_frame), 0);
        chk("full push+pop pass", 32'(b_pass), 1);

        // Unmatched row after a reset that discards FIFO and pipeline.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_ref(1'b1, make_row(i)); tick();
        end
        idle();
        x = make_row(0); x.d[0] = ~x.d[0];
        set_dut(1'b1, x); tick();
        idle();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; model_reset();
        set_ref(1'b1, make_row(0)); set_dut(1'b1, make_row(0)); tick();
        idle();
        chk("unmatched_cnt after 1 cycle", 32'(a_unm), 1);
        tick(); tick();
        chk("reset discards pipeline", 32'(a_data), 0);

        // en low freezes an in-flight compare.
        do_reset();
        r = make_row(0);
        x = r; x.d[2] = r.d[2] + 8'd9;
        set_ref(1'b1, r); tick();
        idle(); set_dut(1'b1, x); tick();
        idle(); en = 1'b0;
        repeat (3) tick();
        chk("en low frozen data_err_cnt", 32'(a_data), 0);
        en = 1'b1; tick();
        chk("en resume data_err_cnt", 32'(a_data), 1);
        chk("en resume lane_err_mask", 32'(a_mask), 32'h04);

        // Saturation on the 4-bit counters, then clear.
        do_reset();
        r = '0;
        x = '0; x.d = {LANES{8'h80}};
        for (int c = 0; c <= 20; c++) begin
            set_ref(c < 20, r); set_dut(c > 0, x); tick();
        end
        idle(); repeat (3) tick();
        chk("saturated data_err_cnt", 32'(b_data), 15);
        chk("saturated frame_err_cnt", 32'(b_frame), 15);
        chk("wide data_err_cnt", 32'(a_data), 20);
        do_clr();
        chk("clr data_err_cnt", 32'(b_data), 0);
        chk("clr frame_err_cnt", 32'(b_frame), 0);
        chk("clr pass", 32'(b_pass), 1);
        chk("clr wide pass", 32'(a_pass), 1);

        random_run(600, 0, "random exact");
        random_run(900, 8, "random noisy");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
